// File: rtl/note_phase_pkg.sv
// note_phase_pkg: shared defaults and the effective-modulus helper for note_phase_divider.
package note_phase_pkg;
    localparam int NPD_DEFAULT_PRESCALE = 524288;
    localparam int NPD_DEFAULT_CHANNELS = 4;
    localparam int NPD_DEFAULT_PHASE_W  = 3;
    function automatic logic [31:0] npd_eff_modulus(input logic [31:0] m);
        return (m == 32'd0) ? 32'd1 : m;
    endfunction
endpackage

// File: rtl/note_phase_divider_if.sv
// note_phase_divider_if: control/phase bundle for note_phase_divider.
// The wrap strobes exist only when NOTE_PHASE_DIV_WRAP_PULSE_EN is defined.
interface note_phase_divider_if
    import note_phase_pkg::*;
#(
    parameter int CHANNELS = NPD_DEFAULT_CHANNELS,
    parameter int PHASE_W  = NPD_DEFAULT_PHASE_W,
    parameter int PRE_W    = $clog2(NPD_DEFAULT_PRESCALE) + 1
);
    logic [PRE_W-1:0]            period;
    logic [CHANNELS-1:0]         en;
    logic [CHANNELS*PHASE_W-1:0] modulus;
    logic                        tick;
    logic [CHANNELS*PHASE_W-1:0] phase;
`ifdef NOTE_PHASE_DIV_WRAP_PULSE_EN
    logic [CHANNELS-1:0]         wrap;
    modport master (output period, en, modulus, input tick, phase, wrap);
    modport slave  (input period, en, modulus, output tick, phase, wrap);
`else
    modport master (output period, en, modulus, input tick, phase);
    modport slave  (input period, en, modulus, output tick, phase);
`endif
endinterface

// File: rtl/note_phase_channel.sv
// note_phase_channel: one phase counter cycling modulo its programmable modulus on each tick.
// Optional wrap register built with NOTE_PHASE_DIV_WRAP_PULSE_EN.
module note_phase_channel
    import note_phase_pkg::*;
#(
    parameter int PHASE_W = NPD_DEFAULT_PHASE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               tick,
    input  logic [PHASE_W-1:0] modulus,
`ifdef NOTE_PHASE_DIV_WRAP_PULSE_EN
    output logic               wrap,
`endif
    output logic [PHASE_W-1:0] phase
);
    logic [PHASE_W-1:0] m_eff;
    logic               last;
    assign m_eff = PHASE_W'(npd_eff_modulus(32'(modulus)));
    // >= so a modulus shrunk below the current phase wraps on the next tick
    assign last  = phase >= m_eff - PHASE_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= '0;
        else if (!en)
            phase <= '0;
        else if (tick)
            phase <= last ? '0 : phase + PHASE_W'(1);
    end
`ifdef NOTE_PHASE_DIV_WRAP_PULSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wrap <= 1'b0;
        else
            wrap <= en & tick & last;
    end
`endif
endmodule

// File: rtl/note_phase_divider.sv
// note_phase_divider: shared programmable prescaler driving CHANNELS independent phase counters.
// Define NOTE_PHASE_DIV_WRAP_PULSE_EN to build the per-channel wrap strobes.
module note_phase_divider
    import note_phase_pkg::*;
#(
    parameter int CHANNELS = NPD_DEFAULT_CHANNELS,
    parameter int PHASE_W  = NPD_DEFAULT_PHASE_W,
    parameter int PRESCALE = NPD_DEFAULT_PRESCALE,
    parameter int PRE_W    = $clog2(PRESCALE) + 1
) (
    input logic clk,
    input logic rst_n,
    note_phase_divider_if.slave bus
);
    localparam logic [PRE_W-1:0] PRE_DEF = PRE_W'(PRESCALE);
    logic [PRE_W-1:0]            cnt;
    logic [PRE_W-1:0]            p_eff;
    logic                        term;
    logic                        tick_q;
    logic [CHANNELS*PHASE_W-1:0] phase_all;
    assign p_eff = (bus.period == '0) ? PRE_DEF : bus.period;
    // >= keeps a shrinking period from overrunning the count
    assign term  = cnt >= p_eff - PRE_W'(1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt    <= term ? '0 : cnt + PRE_W'(1);
            tick_q <= term;
        end
    end
    assign bus.tick  = tick_q;
    assign bus.phase = phase_all;
`ifdef NOTE_PHASE_DIV_WRAP_PULSE_EN
    logic [CHANNELS-1:0] wrap_all;
    assign bus.wrap = wrap_all;
`endif
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        note_phase_channel #(.PHASE_W(PHASE_W)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (bus.en[i]),
            .tick    (tick_q),
            .modulus (bus.modulus[i*PHASE_W +: PHASE_W]),
`ifdef NOTE_PHASE_DIV_WRAP_PULSE_EN
            .wrap    (wrap_all[i]),
`endif
            .phase   (phase_all[i*PHASE_W +: PHASE_W])
        );
    end
endmodule

// File: tb/tb_note_phase_divider.sv
// tb_note_phase_divider: randomized and directed bench against a behavioural model of note_phase_divider.
module tb_note_phase_divider;
    localparam int CH  = 2;
    localparam int PW  = 3;
    localparam int PS  = 4;
    localparam int PRW = $clog2(PS) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    note_phase_divider_if #(.CHANNELS(CH), .PHASE_W(PW), .PRE_W(PRW)) bus ();
    note_phase_divider #(.CHANNELS(CH), .PHASE_W(PW), .PRESCALE(PS), .PRE_W(PRW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: prescaler count, pending tick and per-voice phase as plain integers
    int m_cnt, m_tick, m_p, m_mod;
    int m_ph[CH];
    int m_wr[CH];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0;
            m_tick = 0;
            for (int i = 0; i < CH; i++) begin
                m_ph[i] = 0;
                m_wr[i] = 0;
            end
        end else begin
            m_p = (bus.period == 0) ? PS : int'(bus.period);
            for (int i = 0; i < CH; i++) begin
                m_mod = int'(bus.modulus[i*PW +: PW]);
                if (m_mod == 0) m_mod = 1;
                m_wr[i] = 0;
                if (!bus.en[i]) m_ph[i] = 0;
                else if (m_tick != 0) begin
                    if (m_ph[i] >= m_mod - 1) begin
                        m_ph[i] = 0;
                        m_wr[i] = 1;
                    end else m_ph[i] = m_ph[i] + 1;
                end
            end
            m_tick = (m_cnt >= m_p - 1) ? 1 : 0;
            m_cnt  = (m_cnt >= m_p - 1) ? 0 : m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("tick", 32'(bus.tick), 32'(m_tick));
            for (int i = 0; i < CH; i++) begin
                check($sformatf("phase%0d", i), 32'(bus.phase[i*PW +: PW]), 32'(m_ph[i]));
`ifdef NOTE_PHASE_DIV_WRAP_PULSE_EN
                check($sformatf("wrap%0d", i), 32'(bus.wrap[i]), 32'(m_wr[i]));
`endif
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_tick"}, 32'(bus.tick), 0);
        check({tag, "_phase"}, 32'(bus.phase), 0);
`ifdef NOTE_PHASE_DIV_WRAP_PULSE_EN
        check({tag, "_wrap"}, 32'(bus.wrap), 0);
`endif
    endtask

    task automatic release_and_time_tick(input string tag);
        int c = 0;
        bit seen = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            if (bus.tick) seen = 1;
        end
        check(tag, seen ? 32'(c) : 32'd0, 32'd4);
    endtask

    task automatic wait_tick(input string tag);
        bit seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.tick) seen = 1;
        end
        check(tag, 32'(seen), 1);
    endtask

    initial begin
        bit found;
        bus.period  = '0;
        bus.en      = '0;
        bus.modulus = '0;
        #3 check_zero("reset");
        release_and_time_tick("first_tick_cycle");
        repeat (10) @(negedge clk);

        bus.en = 2'b11;
        bus.modulus = {3'd3, 3'd5};
        repeat (40) @(negedge clk);

        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (bus.phase[PW-1:0] == 3'd4) found = 1;
        end
        check("reach_phase4", 32'(found), 1);
        bus.modulus[PW-1:0] = 3'd2;
        repeat (20) @(negedge clk);

        bus.modulus[2*PW-1:PW] = 3'd0;
        bus.period = PRW'(1);
        repeat (12) @(negedge clk);

        bus.period = '0;
        wait_tick("tick_for_drop");
        bus.en = 2'b10;
        @(negedge clk);
        check("drop_phase0", 32'(bus.phase[PW-1:0]), 0);
        repeat (6) @(negedge clk);

        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) bus.period = PRW'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) bus.en = CH'($urandom);
            if ($urandom_range(0, 7) == 0) bus.modulus[$urandom_range(0, CH-1)*PW +: PW] = PW'($urandom);
        end

        bus.period = '0;
        bus.en = 2'b11;
        bus.modulus = {3'd3, 3'd5};
        repeat (13) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        release_and_time_tick("tick_after_reset");
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/note_phase_divider.md
# note_phase_divider

Multi-channel successor to the organ's single-note clock divider. One shared prescaler, with a runtime-programmable period, generates a one-cycle `tick`. Each of `CHANNELS` independent phase counters advances on that tick and cycles modulo its own programmable `modulus`. The block sits between the system clock and the tone/envelope generators and supplies every voice with a slow phase index and, optionally, a wrap strobe.

## Interface
- `CHANNELS`, default 4: number of independent phase channels (≥1).
- `PHASE_W`, default 3: width of each phase counter and modulus field.
- `PRESCALE`, default 524288 (2^19): default prescaler period in clk cycles (≥1).
- `PRE_W`, default `$clog2(PRESCALE)+1`: width of the prescaler counter and the `period` port.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `period`, input, `PRE_W`: runtime prescaler period; 0 selects `PRESCALE`.
- `en`, input, `CHANNELS`: per-channel enable.
- `modulus`, input, `CHANNELS*PHASE_W`: per-channel modulus; channel i uses bits [i*PHASE_W +: PHASE_W].
- `tick`, output, 1: registered one-cycle prescaler strobe.
- `phase`, output, `CHANNELS*PHASE_W`: per-channel phase, packed like `modulus`.
- `wrap`, output, `CHANNELS`: per-channel wrap strobe. Present only with `NOTE_PHASE_DIV_WRAP_PULSE_EN`.

## Operation
- Effective period is `P = (period==0) ? PRESCALE : period`.
- Prescaler `cnt` runs 0…P-1. It is terminal when `cnt >= P-1`. On the terminal value it returns to 0; otherwise it increments.
  - Because terminal uses `>=`, shrinking `period` mid-count never overruns.
  - P=1 makes `cnt` terminal every cycle.
- `tick` is registered: it is 1 in the cycle after a terminal `cnt`, and 0 otherwise. With P=1, `tick` stays high continuously after the first cycle.
- Channel i, with effective modulus `M = (modulus_i==0) ? 1 : modulus_i`:
  - If `en[i]==0`, phase_i is synchronously forced to 0 and wrap_i is 0. This applies regardless of `tick`.
  - If `en[i]==1` and `tick==1`:
    - If `phase_i >= M-1`, phase_i becomes 0 and wrap_i pulses.
    - Otherwise phase_i increments.
  - If `en[i]==1` and `tick==0`, the phase holds.
- Comparing with `>=` makes a modulus reduced below the current phase wrap to 0 on the next tick. No out-of-range value ever persists past one tick.
- M=1 holds the phase at 0 and produces a wrap on every tick.
- `modulus` and `period` are sampled every cycle. There is no load handshake.
- Channels are fully independent and share only `tick`.
- All arithmetic is unsigned. Counters never exceed their width because of the `>=` terminal rules.

## Timing
- Reset values: `cnt`=0, `tick`=0, all `phase`=0, all `wrap`=0.
- Latency from a terminal `cnt` to `tick` is 1 cycle.
- Latency from `tick` to the updated `phase` and the `wrap` pulse is 1 cycle. `wrap` is high in the same cycle the new phase (0) appears.
- Tick spacing is exactly P cycles in steady state. The first `tick` after reset is high in cycle P, counting the first active edge as cycle 1.
- When `en[i]` rises, phase_i starts from 0. The first increment occurs on the next `tick`.
- When `en[i]` and `tick` fall together, the clear wins.
- Reset asserted mid-operation immediately returns all state to reset values. Counting resumes from `cnt`=0 after deassertion.

## Configuration
- `NOTE_PHASE_DIV_WRAP_PULSE_EN` defined: the `wrap` port and its per-channel registers are built, behaving as described above.
- Not defined: the `wrap` port and logic are absent. `phase` and `tick` behaviour is unchanged and cycle-identical.

## Structure
- Package `note_phase_pkg` holds:
  - constants `NPD_DEFAULT_PRESCALE` = 524288, `NPD_DEFAULT_CHANNELS` = 4, `NPD_DEFAULT_PHASE_W` = 3;
  - a function computing the effective modulus (0→1).
- Sub-module `note_phase_channel`: one phase counter with its enable, modulus, and optional wrap register. It is instantiated `CHANNELS` times in a generate loop.
- The prescaler and `tick` register live in the top level.

## Test plan
All scenarios use PRESCALE=4, PHASE_W=3, CHANNELS=2, with the macro defined unless stated.
- Reset release, period=0 → `tick` high in cycles 4, 8, 12. `phase` stays 0 until en asserts.
- en=2'b11, modulus={3'd3,3'd5} → ch0 phase goes 0,1,2,3,4,0 on successive ticks with wrap on the 0. Ch1 goes 0,1,2,0 with wrap.
- Ch0 at phase 4, modulus changed to 2 → next tick gives phase 0 with wrap. The sequence then runs 0,1,0.
- modulus=0 on ch1 → phase 0 on every tick, with wrap on every tick. period=1 → `tick` is constant 1 and ch0 advances every cycle.
- en[0] dropped in the same cycle as `tick` → phase0 is 0 the next cycle, with no wrap. Ch1 is unaffected.
- rst_n pulsed low mid-count with phases nonzero → all outputs 0 asynchronously. The next tick arrives 4 cycles after release. Rebuilding without the macro gives identical `phase`/`tick` traces.
